dff_pipe: RTL and testbench
===========================

# dff_pipe

`dff_pipe` is a parametrised successor to the single-bit D flip-flop. It is a WIDTH-bit, DEPTH-stage registered delay line. Each stage has a valid bit, and the block adds a shift enable (stall), a flush, a runtime-selectable output tap and an occupancy counter. It sits wherever a datapath needs a fixed or selectable cycle delay with qualification, for example in retiming and for aligning side-band data with pipelined arithmetic.

## Interface
- WIDTH, 8: data width in bits, ≥1.
- DEPTH, 4: number of register stages, ≥1.
- RST_VAL, 0: WIDTH-bit value loaded into every data stage on reset.
- TW (localparam): tap index width, max(1, $clog2(DEPTH)).
- CW (localparam): count width, $clog2(DEPTH+1).
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  shift enable; 0 = stall (hold all stages).
- flush  in  1  clear all valid bits on the next edge.
- d  in  WIDTH  input data, sampled when en=1.
- d_valid  in  1  qualifies d; captured into stage 0's valid bit.
- tap  in  TW  selects the stage driven onto q_tap (0 = first stage).
- q  out  WIDTH  data of the last stage (DEPTH-1).
- q_valid  out  1  valid bit of the last stage.
- q_tap  out  WIDTH  data of stage `tap`.
- q_tap_valid  out  1  valid bit of stage `tap`.
- count  out  CW  number of stages whose valid bit is 1.

## Operation
- **State:** data[0..DEPTH-1] (WIDTH bits each), v[0..DEPTH-1], and the count register.
- **Edge priority**, highest first: rst, then flush, then en, then hold.
- **rst=1:**
  - every data stage = RST_VAL; every v = 0; count = 0.
  - d, en and flush are ignored.
- **flush=1 (rst=0):**
  - every v = 0 and count = 0.
  - data stages keep their values.
  - The input on that edge is dropped, even if en=1.
- **en=1 (rst=0, flush=0):**
  - data[0] ← d and v[0] ← d_valid.
  - data[i] ← data[i-1] and v[i] ← v[i-1] for i = 1..DEPTH-1.
  - The old data[DEPTH-1] is discarded.
  - Data shifts regardless of d_valid; invalid entries occupy stages as bubbles.
- **en=0:** all state holds.
- **Counter:** when en=1, count ← count + d_valid − v[DEPTH-1] (old value).
  - Simultaneous entry and exit leaves count unchanged.
  - count must equal popcount(v) at every cycle; the bench checks this invariant continuously.
- **Outputs:**
  - q, q_valid, count: direct register outputs.
  - q_tap, q_tap_valid: combinational mux of the stage registers indexed by tap.
  - If tap ≥ DEPTH (possible when DEPTH is not a power of two), tap clamps to DEPTH-1.
- **DEPTH=1:** the block degenerates to a single enabled, flushable register with a valid bit. tap is 1 bit; tap=1 clamps to stage 0.

## Timing
- Reset values: q = RST_VAL, q_valid = 0, count = 0. q_tap = RST_VAL and q_tap_valid = 0 for any tap.
- **Latency to q:** d captured at an enabled edge appears on q after exactly DEPTH enabled edges. With en held at 1, that is DEPTH cycles.
- **Latency to q_tap:** data appears on q_tap after tap+1 enabled edges.
- Stalled cycles (en=0) add latency one-for-one; no data is lost or duplicated.
- **tap changes:** take effect in the same cycle, with no registered delay on the tap path.
- **rst or flush mid-stream:** all in-flight entries are lost. The first valid output after that appears DEPTH enabled edges after the next d_valid=1 capture.
- **Full occupancy:** count = DEPTH. Continued shifting with d_valid=1 keeps count = DEPTH; there is no overflow, because one entry exits as one enters.

## Test plan
- **Reset:** WIDTH=8, DEPTH=4, RST_VAL=8'hA5. Assert rst for 2 cycles with d=8'hFF, en=1, d_valid=1. Required: q=8'hA5, q_valid=0, count=0, and q_tap=8'hA5 for tap=0..3.
- **Streaming:** en=1, d_valid=1, d=1,2,3,4,5 on consecutive edges. Required:
  - q=1 with q_valid=1 on the 4th edge after d=1 was captured.
  - count goes 1,2,3,4,4.
  - with tap=1, q_tap shows each value 2 edges after capture.
- **Stall:** load 8'h11, 8'h22, then hold en=0 for 3 cycles, then en=1. Required: all outputs frozen during the stall; 8'h11 reaches q after 4 enabled edges in total; count stays at 2 throughout the stall.
- **Bubbles and count invariant:** random d_valid with en=1 for 200 cycles. Required: count == popcount(v) every cycle, and q_valid follows d_valid delayed by 4 enabled edges.
- **Flush precedence:** with count=3, assert flush=1, en=1, d_valid=1, d=8'h77. Required: next cycle count=0, q_valid=0, and 8'h77 never appears as valid.
- **DEPTH=3 clamp:** drive tap=3 with a full pipeline. Required: q_tap == q and q_tap_valid == q_valid every cycle.

Source files
------------

// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage registered delay line with one valid bit
// per stage. It supports stall (en=0), flush, a runtime-selectable output
// tap and an occupancy counter that tracks the number of valid stages.
module dff_pipe #(
   parameter int               WIDTH   = 8,
   parameter int               DEPTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   localparam int              TW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int              CW      = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic [WIDTH-1:0] d,
   input  logic             d_valid,
   input  logic [TW-1:0]    tap,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic [WIDTH-1:0] q_tap,
   output logic             q_tap_valid,
   output logic [CW-1:0]    count
);

   // Stage storage: stage 0 is the newest entry and stage DEPTH-1 the oldest.
   logic [WIDTH-1:0] r_data [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [CW-1:0]    r_count;

   // Tap mux results.
   logic [WIDTH-1:0] w_tap_data;
   logic             w_tap_valid;

   // Data stages: reset to RST_VAL, otherwise shift on en. A flush leaves
   // the data untouched because the cleared valid bits already hide it.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the data stages are individual flops, not a RAM, so each
         // one can take a defined reset value.
         for (int i = 0; i < DEPTH; i++) begin
            r_data[i] <= RST_VAL;
         end
      end else if (!flush && en) begin
         // NOTE: non-blocking assignments make every stage load its
         // neighbour's pre-edge value, whatever the loop order.
         r_data[0] <= d;
         for (int i = 1; i < DEPTH; i++) begin
            r_data[i] <= r_data[i-1];
         end
      end
   end

   // Valid bits and occupancy: rst and flush both empty the pipe. While
   // shifting, the count rises for an entering valid and falls for the
   // valid that leaves the last stage, so it always matches popcount(v).
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_valid <= '0;
         r_count <= '0;
      end else if (en) begin
         r_valid[0] <= d_valid;
         for (int i = 1; i < DEPTH; i++) begin
            r_valid[i] <= r_valid[i-1];
         end
         r_count <= r_count + CW'(d_valid) - CW'(r_valid[DEPTH-1]);
      end
   end

   // Tap select. When tap >= DEPTH no stage index matches, so the output
   // falls back to the last stage. This gives the clamp.
   always_comb begin
      // NOTE: the defaults come first so that every path assigns both outputs
      // and no latch is inferred.
      w_tap_data  = r_data[DEPTH-1];
      w_tap_valid = r_valid[DEPTH-1];
      for (int i = 0; i < DEPTH; i++) begin
         if (tap == TW'(i)) begin
            w_tap_data  = r_data[i];
            w_tap_valid = r_valid[i];
         end
      end
   end

   assign q           = r_data[DEPTH-1];
   assign q_valid     = r_valid[DEPTH-1];
   assign q_tap       = w_tap_data;
   assign q_tap_valid = w_tap_valid;
   assign count       = r_count;

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe. Instance A has DEPTH=4 and RST_VAL=A5.
// Instance B has DEPTH=3 and RST_VAL=3C, so its tap=3 must clamp.
// Both instances share the same input stream.
module tb_dff_pipe;

   localparam logic [7:0] RA = 8'hA5;
   localparam logic [7:0] RB = 8'h3C;

   logic       clk = 1'b0;
   logic       rst, en, flush, d_valid;
   logic [7:0] d;
   logic [1:0] tap_a, tap_b;

   logic [7:0] q_a, qt_a, q_b, qt_b;
   logic       qv_a, qtv_a, qv_b, qtv_b;
   logic [2:0] cnt_a;
   logic [1:0] cnt_b;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(RA)) u_a (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
      .tap(tap_a), .q(q_a), .q_valid(qv_a), .q_tap(qt_a),
      .q_tap_valid(qtv_a), .count(cnt_a)
   );

   dff_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(RB)) u_b (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
      .tap(tap_b), .q(q_b), .q_valid(qv_b), .q_tap(qt_b),
      .q_tap_valid(qtv_b), .count(cnt_b)
   );

   // Reference model. Each instance keeps a queue of {data, valid}. Element
   // 0 is the newest capture. An enabled edge pushes at the front and drops
   // the oldest element. A flush invalidates every entry.
   typedef struct packed {
      logic [7:0] d;
      logic       v;
   } ent_t;

   ent_t ma[$];
   ent_t mb[$];

   typedef struct {
      bit         r, e, f, dv;
      logic [7:0] d;
      logic [1:0] t;
      logic [7:0] eq;
      bit         eqv;
      int         ec;
      logic [7:0] eqt;
      bit         eqtv;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit r, bit e, bit f, bit dv, logic [7:0] dd,
                               logic [1:0] t, logic [7:0] eq, bit eqv, int ec,
                               logic [7:0] eqt, bit eqtv);
      vec_t v;
      v.r = r; v.e = e; v.f = f; v.dv = dv; v.d = dd; v.t = t;
      v.eq = eq; v.eqv = eqv; v.ec = ec; v.eqt = eqt; v.eqtv = eqtv;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      ent_t e;
      ma = {};
      mb = {};
      e.d = RA; e.v = 1'b0;
      repeat (4) ma.push_back(e);
      e.d = RB;
      repeat (3) mb.push_back(e);
   endtask

   function automatic int pop_a();
      int s = 0;
      foreach (ma[i]) s += int'(ma[i].v);
      return s;
   endfunction

   function automatic int pop_b();
      int s = 0;
      foreach (mb[i]) s += int'(mb[i].v);
      return s;
   endfunction

   task automatic check_a_model();
      int idx;
      idx = int'(tap_a);
      check("a_q",       q_a,   ma[3].d);
      check("a_q_valid", qv_a,  ma[3].v);
      check("a_count",   cnt_a, pop_a());
      check("a_q_tap",   qt_a,  ma[idx].d);
      check("a_tap_vld", qtv_a, ma[idx].v);
   endtask

   task automatic check_b_model();
      int idx;
      idx = (tap_b > 2'd2) ? 2 : int'(tap_b);
      check("b_q",       q_b,   mb[2].d);
      check("b_q_valid", qv_b,  mb[2].v);
      check("b_count",   cnt_b, pop_b());
      check("b_q_tap",   qt_b,  mb[idx].d);
      check("b_tap_vld", qtv_b, mb[idx].v);
   endtask

   // Drives one cycle from a negedge, updates the model at the posedge and
   // checks instance B against the model at the following negedge.
   task automatic apply(input bit r, input bit e, input bit f, input bit dv,
                        input logic [7:0] dd, input logic [1:0] ta,
                        input logic [1:0] tb);
      ent_t n;
      rst = r; en = e; flush = f; d_valid = dv; d = dd; tap_a = ta; tap_b = tb;
      @(posedge clk);
      if (r) begin
         model_reset();
      end else if (f) begin
         foreach (ma[i]) ma[i].v = 1'b0;
         foreach (mb[i]) mb[i].v = 1'b0;
      end else if (e) begin
         n.d = dd; n.v = dv;
         ma.push_front(n); void'(ma.pop_back());
         mb.push_front(n); void'(mb.pop_back());
      end
      @(negedge clk);
      check_b_model();
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; flush = 1'b0; d_valid = 1'b0; d = '0;
      tap_a = '0; tap_b = 2'd3;
      model_reset();

      // Directed vectors for instance A, with expectations worked out by hand.
      // Reset with active inputs, which must be ignored.
      vecs.push_back(mk(1,1,0,1,8'hFF,0, RA,0,0, RA,0));
      vecs.push_back(mk(1,1,0,1,8'hFF,0, RA,0,0, RA,0));
      // Streaming 1..5 with tap=1.
      vecs.push_back(mk(0,1,0,1,8'h01,1, RA,0,1, RA,0));
      vecs.push_back(mk(0,1,0,1,8'h02,1, RA,0,2, 8'h01,1));
      vecs.push_back(mk(0,1,0,1,8'h03,1, RA,0,3, 8'h02,1));
      vecs.push_back(mk(0,1,0,1,8'h04,1, 8'h01,1,4, 8'h03,1));
      vecs.push_back(mk(0,1,0,1,8'h05,1, 8'h02,1,4, 8'h04,1));
      // Stall: load 11, 22, hold for three cycles, then shift bubbles.
      vecs.push_back(mk(1,0,0,0,8'h00,0, RA,0,0, RA,0));
      vecs.push_back(mk(0,1,0,1,8'h11,0, RA,0,1, 8'h11,1));
      vecs.push_back(mk(0,1,0,1,8'h22,0, RA,0,2, 8'h22,1));
      vecs.push_back(mk(0,0,0,1,8'h99,0, RA,0,2, 8'h22,1));
      vecs.push_back(mk(0,0,0,1,8'h99,0, RA,0,2, 8'h22,1));
      vecs.push_back(mk(0,0,0,1,8'h99,0, RA,0,2, 8'h22,1));
      vecs.push_back(mk(0,1,0,0,8'h00,0, RA,0,2, 8'h00,0));
      vecs.push_back(mk(0,1,0,0,8'h00,0, 8'h11,1,2, 8'h00,0));
      // Flush takes precedence over en. Data stays and 77 is never valid.
      vecs.push_back(mk(1,0,0,0,8'h00,0, RA,0,0, RA,0));
      vecs.push_back(mk(0,1,0,1,8'h31,0, RA,0,1, 8'h31,1));
      vecs.push_back(mk(0,1,0,1,8'h32,0, RA,0,2, 8'h32,1));
      vecs.push_back(mk(0,1,0,1,8'h33,0, RA,0,3, 8'h33,1));
      vecs.push_back(mk(0,1,1,1,8'h77,0, RA,0,0, 8'h33,0));
      vecs.push_back(mk(0,1,0,0,8'h00,0, 8'h31,0,0, 8'h00,0));
      vecs.push_back(mk(0,1,0,0,8'h00,0, 8'h32,0,0, 8'h00,0));
      vecs.push_back(mk(0,1,0,0,8'h00,0, 8'h33,0,0, 8'h00,0));
      vecs.push_back(mk(0,1,0,0,8'h00,0, 8'h00,0,0, 8'h00,0));
      // rst beats flush. A flush with en=0 still clears the valid bits.
      vecs.push_back(mk(0,1,0,1,8'h44,0, 8'h00,0,1, 8'h44,1));
      vecs.push_back(mk(1,1,1,1,8'h55,0, RA,0,0, RA,0));
      vecs.push_back(mk(0,1,0,1,8'h66,0, RA,0,1, 8'h66,1));
      vecs.push_back(mk(0,0,1,0,8'h00,0, RA,0,0, 8'h66,0));

      @(negedge clk);
      foreach (vecs[k]) begin
         apply(vecs[k].r, vecs[k].e, vecs[k].f, vecs[k].dv, vecs[k].d,
               vecs[k].t, 2'd3);
         check($sformatf("vec%0d_q", k),       q_a,   vecs[k].eq);
         check($sformatf("vec%0d_q_valid", k), qv_a,  vecs[k].eqv);
         check($sformatf("vec%0d_count", k),   cnt_a, vecs[k].ec);
         check($sformatf("vec%0d_q_tap", k),   qt_a,  vecs[k].eqt);
         check($sformatf("vec%0d_tap_vld", k), qtv_a, vecs[k].eqtv);
      end

      // After reset, every tap shows RST_VAL and is invalid. Taps are
      // combinational, so there is no clock between select and check.
      apply(1,0,0,0,8'h00,0,3);
      apply(1,0,0,0,8'h00,0,3);
      for (int t = 0; t < 4; t++) begin
         tap_a = 2'(t);
         tap_b = 2'(t);
         #1;
         check($sformatf("rst_tap%0d_a", t), qt_a,  RA);
         check($sformatf("rst_tap%0d_av", t), qtv_a, 1'b0);
         check($sformatf("rst_tap%0d_b", t), qt_b,  RB);
      end

      // Full occupancy. Count saturates at DEPTH with no overflow. B's
      // tap=3 clamps to stage 2, i.e. the value captured two edges earlier.
      for (int k = 0; k < 7; k++) begin
         apply(0,1,0,1,8'(8'h40 + k),2,3);
         check_a_model();
         if (k >= 3) check($sformatf("full_count_%0d", k), cnt_a, 3'd4);
         if (k >= 2) begin
            check($sformatf("clamp_b_%0d", k), qt_b, 8'(8'h40 + k - 2));
            check($sformatf("clamp_bv_%0d", k), qtv_b, 1'b1);
         end
      end

      // Random bubbles with en held at 1.
      for (int k = 0; k < 200; k++) begin
         apply(0, 1, 0, 1'($urandom_range(1)), 8'($urandom), 2'($urandom),
               2'($urandom));
         check_a_model();
      end

      // Random stalls, flushes and occasional resets.
      for (int k = 0; k < 300; k++) begin
         apply(($urandom_range(99) == 0), ($urandom_range(3) != 0),
               ($urandom_range(29) == 0), 1'($urandom_range(1)), 8'($urandom),
               2'($urandom), 2'($urandom));
         check_a_model();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
